// File: rtl/free_list_pkg.sv
// ---------------------------------------------------------------------------
// free_list_pkg
// Shared constants and types for the physical-register free list. The rename
// stage and the reorder buffer import the same package so that tag widths,
// register counts and 4-lane bus packing agree across the pipeline.
//   WIDTH_REG : physical register tag width
//   NPREG     : number of physical registers (free-list depth, power of two)
//   NAREG     : architectural registers, tags 0..NAREG-1 mapped at reset
//   NLANE     : allocate/release lanes per cycle
//   lane_tag  : extracts lane i from a packed 4-lane tag bus
// ---------------------------------------------------------------------------
package free_list_pkg;

   localparam int WIDTH_REG = 7;
   localparam int NPREG     = 128;
   localparam int NAREG     = 32;
   localparam int NLANE     = 4;
   localparam int PTR_W     = $clog2(NPREG);
   localparam int CNT_W     = WIDTH_REG + 1;

   typedef logic [WIDTH_REG-1:0]       tag_t;
   typedef logic [PTR_W-1:0]           ptr_t;
   typedef logic [CNT_W-1:0]           cnt_t;
   typedef logic [CNT_W:0]             sum_t;
   typedef logic [NLANE*WIDTH_REG-1:0] tag4x_t;

   // Lane i occupies bits [(i+1)*WIDTH_REG-1 : i*WIDTH_REG].
   function automatic tag_t lane_tag(input tag4x_t bus, input int lane);
      return bus[lane*WIDTH_REG +: WIDTH_REG];
   endfunction

endpackage

// File: rtl/free_list_lane_compact.sv
// ---------------------------------------------------------------------------
// lane_compact
// Purely combinational lane compaction helper. For every lane it reports how
// many set mask bits sit in lower-numbered lanes, which is the offset of that
// lane's slot relative to the head (or tail) pointer.
//   i_mask   : per-lane active mask
//   o_offset : per-lane offset 0..3 (meaningful only where the mask bit is set)
//   o_count  : popcount of i_mask, 0..4
// ---------------------------------------------------------------------------
module lane_compact
   import free_list_pkg::*;
(
   input  logic [NLANE-1:0]      i_mask,
   output logic [NLANE-1:0][1:0] o_offset,
   output logic [2:0]            o_count
);

   logic [2:0] run;

   // Running prefix count: each lane takes the count of set lanes below it.
   always_comb begin
      run      = '0;
      o_offset = '0;
      for (int i = 0; i < NLANE; i++) begin
         o_offset[i] = run[1:0];
         run         = run + {2'b00, i_mask[i]};
      end
      o_count = run;
   end

endmodule

// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
// 4-wide circular free list of physical register tags. Rename pulls up to four
// tags per cycle from the head; committed (or squashed) instructions return
// their tags at the tail through the ROB commit lanes.
//   i_clk, i_rst   : clock (rising edge), asynchronous active-high reset
//   i_alloc_req    : per-lane tag request from rename
//   i_alloc_we     : rename commits the allocation this cycle
//   o_alloc_ok     : enough free tags for popcount(i_alloc_req)
//   o_prd4x        : allocated tag per lane, 0 on non-requesting lanes
//   i_com_prd4x    : tags released at commit, same packing as o_prd4x
//   i_com_en       : per-lane release valid
//   o_count        : number of free tags
//   o_empty        : no free tags
//   o_error        : sticky overflow / tag-0 release flag
// ---------------------------------------------------------------------------
module free_list
   import free_list_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [NLANE-1:0] i_alloc_req,
   input  logic             i_alloc_we,
   output logic             o_alloc_ok,
   output tag4x_t           o_prd4x,
   input  tag4x_t           i_com_prd4x,
   input  logic [NLANE-1:0] i_com_en,
   output cnt_t             o_count,
   output logic             o_empty,
   output logic             o_error
);

   tag_t fl_q [NPREG];
   tag_t fl_d [NPREG];
   ptr_t head_q, head_d;
   ptr_t tail_q, tail_d;
   cnt_t count_q, count_d;
   logic error_q, error_d;

   logic [NLANE-1:0]      push_valid;
   logic                  zero_release;
   logic [NLANE-1:0][1:0] alloc_off;
   logic [NLANE-1:0][1:0] rel_off;
   logic [2:0]            alloc_npop;
   logic [2:0]            rel_npush;
   logic                  pop_fire;
   sum_t                  count_sum;

   // A release of tag 0 is a protocol violation: it is dropped and flagged.
   always_comb begin
      push_valid = '0;
      for (int i = 0; i < NLANE; i++) begin
         push_valid[i] = i_com_en[i] && (lane_tag(i_com_prd4x, i) != '0);
      end
      zero_release = |(i_com_en & ~push_valid);
   end

   lane_compact u_alloc_compact (
      .i_mask   (i_alloc_req),
      .o_offset (alloc_off),
      .o_count  (alloc_npop)
   );

   lane_compact u_rel_compact (
      .i_mask   (push_valid),
      .o_offset (rel_off),
      .o_count  (rel_npush)
   );

   assign o_alloc_ok = (count_q >= cnt_t'(alloc_npop));
   assign pop_fire   = i_alloc_we && o_alloc_ok;
   assign o_count    = count_q;
   assign o_empty    = (count_q == '0);
   assign o_error    = error_q;

   // Zero-cycle read: requesting lanes see consecutive entries from head,
   // with pointer arithmetic wrapping naturally at the PTR_W width.
   always_comb begin
      o_prd4x = '0;
      for (int i = 0; i < NLANE; i++) begin
         if (i_alloc_req[i]) begin
            o_prd4x[i*WIDTH_REG +: WIDTH_REG] = fl_q[ptr_t'(head_q + ptr_t'(alloc_off[i]))];
         end
      end
   end

   // Next-state: released tags land at tail in lane order; the pop only ever
   // reads start-of-cycle contents, so no bypass path exists.
   always_comb begin
      fl_d = fl_q;
      for (int i = 0; i < NLANE; i++) begin
         if (push_valid[i]) begin
            fl_d[ptr_t'(tail_q + ptr_t'(rel_off[i]))] = lane_tag(i_com_prd4x, i);
         end
      end
      head_d    = pop_fire ? ptr_t'(head_q + ptr_t'(alloc_npop)) : head_q;
      tail_d    = ptr_t'(tail_q + ptr_t'(rel_npush));
      count_sum = sum_t'(count_q) + sum_t'(rel_npush) - (pop_fire ? sum_t'(alloc_npop) : '0);
      count_d   = count_sum[CNT_W-1:0];
      error_d   = error_q || zero_release || (count_sum > sum_t'(NPREG));
   end

   // Reset maps tags 0..NAREG-1 to the architectural state, so only
   // NAREG..NPREG-1 start out free.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < NPREG; k++) begin
            fl_q[k] <= (k < NPREG - NAREG) ? tag_t'(NAREG + k) : '0;
         end
         head_q  <= '0;
         tail_q  <= ptr_t'(NPREG - NAREG);
         count_q <= cnt_t'(NPREG - NAREG);
         error_q <= 1'b0;
      end else begin
         fl_q    <= fl_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         error_q <= error_d;
      end
   end

endmodule

// File: tb/tb_free_list.sv
// ---------------------------------------------------------------------------
// tb_free_list
// Directed bench for free_list. A queue of free tags models the pool; every
// step pushes its expectations onto a scoreboard and checkOutput pops and
// compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_free_list;
   import free_list_pkg::*;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic [NLANE-1:0] i_alloc_req;
   logic             i_alloc_we;
   logic             o_alloc_ok;
   tag4x_t           o_prd4x;
   tag4x_t           i_com_prd4x;
   logic [NLANE-1:0] i_com_en;
   cnt_t             o_count;
   logic             o_empty;
   logic             o_error;

   int checks = 0;
   int errors = 0;

   int unsigned modelQ[$];
   bit          modelErr;

   string       sbName[$];
   int          sbSig[$];
   logic [31:0] sbExp[$];

   localparam int SIG_OK    = 0;
   localparam int SIG_PRD   = 1;
   localparam int SIG_COUNT = 2;
   localparam int SIG_EMPTY = 3;
   localparam int SIG_ERROR = 4;

   free_list dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_alloc_req (i_alloc_req),
      .i_alloc_we  (i_alloc_we),
      .o_alloc_ok  (o_alloc_ok),
      .o_prd4x     (o_prd4x),
      .i_com_prd4x (i_com_prd4x),
      .i_com_en    (i_com_en),
      .o_count     (o_count),
      .o_empty     (o_empty),
      .o_error     (o_error)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 i_clk = ~i_clk;

   function automatic tag4x_t pack4(input int l3, input int l2, input int l1, input int l0);
      tag4x_t b;
      b = {tag_t'(l3), tag_t'(l2), tag_t'(l1), tag_t'(l0)};
      return b;
   endfunction

   function automatic logic [31:0] observe(input int sig);
      logic [31:0] v;
      v = '0;
      case (sig)
         SIG_OK:    v = 32'(o_alloc_ok);
         SIG_PRD:   v = 32'(o_prd4x);
         SIG_COUNT: v = 32'(o_count);
         SIG_EMPTY: v = 32'(o_empty);
         default:   v = 32'(o_error);
      endcase
      return v;
   endfunction

   task automatic expectVal(input string name, input int sig, input logic [31:0] value);
      sbName.push_back(name);
      sbSig.push_back(sig);
      sbExp.push_back(value);
   endtask

   // Drains the scoreboard, comparing each entry with the live DUT output.
   task automatic checkOutput();
      string       n;
      int          s;
      logic [31:0] e;
      logic [31:0] obs;
      while (sbExp.size() > 0) begin
         n   = sbName.pop_front();
         s   = sbSig.pop_front();
         e   = sbExp.pop_front();
         obs = observe(s);
         checks++;
         assert (obs === e) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", n, obs, e);
         end
      end
   endtask

   task automatic modelReset();
      modelQ.delete();
      for (int k = NAREG; k < NPREG; k++) modelQ.push_back(k);
      modelErr = 1'b0;
   endtask

   // Asynchronous reset: values must appear without waiting for a clock edge.
   task automatic resetDut();
      i_rst = 1'b1;
      modelReset();
      #1;
      expectVal("rst_count", SIG_COUNT, 32'd96);
      expectVal("rst_empty", SIG_EMPTY, 32'd0);
      expectVal("rst_error", SIG_ERROR, 32'd0);
      checkOutput();
      @(negedge i_clk);
      i_rst       = 1'b0;
      i_alloc_req = '0;
      i_alloc_we  = 1'b0;
      i_com_en    = '0;
      i_com_prd4x = '0;
   endtask

   // One cycle: drive at the falling edge, check combinational allocation
   // against the model, advance the model across the rising edge, then check
   // the registered state.
   task automatic applyStimulus(input logic [3:0] req, input logic we,
                                input logic [3:0] en, input tag4x_t tags);
      int     npop;
      bit     ok;
      int     j;
      tag4x_t expBus;
      tag_t   t;
      @(negedge i_clk);
      i_alloc_req = req;
      i_alloc_we  = we;
      i_com_en    = en;
      i_com_prd4x = tags;
      #1;
      npop = $countones(req);
      ok   = (modelQ.size() >= npop);
      expectVal("alloc_ok", SIG_OK, 32'(ok));
      if (ok) begin
         expBus = '0;
         j      = 0;
         for (int i = 0; i < NLANE; i++) begin
            if (req[i]) begin
               expBus[i*WIDTH_REG +: WIDTH_REG] = tag_t'(modelQ[j]);
               j++;
            end
         end
         expectVal("prd4x", SIG_PRD, 32'(expBus));
      end
      checkOutput();
      if (we && ok) begin
         for (int i = 0; i < npop; i++) void'(modelQ.pop_front());
      end
      for (int i = 0; i < NLANE; i++) begin
         if (en[i]) begin
            t = tags[i*WIDTH_REG +: WIDTH_REG];
            if (t == '0) modelErr = 1'b1;
            else         modelQ.push_back(int'(t));
         end
      end
      @(posedge i_clk);
      #1;
      expectVal("count", SIG_COUNT, 32'(modelQ.size()));
      expectVal("empty", SIG_EMPTY, 32'(modelQ.size() == 0));
      expectVal("error", SIG_ERROR, 32'(modelErr));
      checkOutput();
   endtask

   initial begin
      logic [3:0] rq;
      logic [3:0] en;
      tag4x_t     tg;
      int         net;

      i_alloc_req = '0;
      i_alloc_we  = 1'b0;
      i_com_en    = '0;
      i_com_prd4x = '0;

      // Reset state, with a full 4-lane request visible before the first edge.
      i_rst       = 1'b1;
      i_alloc_req = 4'b1111;
      #1;
      expectVal("rst_ok", SIG_OK, 32'd1);
      expectVal("rst_prd_1111", SIG_PRD, 32'(pack4(35, 34, 33, 32)));
      checkOutput();
      resetDut();

      // Full-width allocation, then lane0 shows the next free tag.
      applyStimulus(4'b1111, 1'b1, 4'b0000, '0);
      applyStimulus(4'b0001, 1'b0, 4'b0000, '0);
      expectVal("after_pop4_count", SIG_COUNT, 32'd92);
      expectVal("after_pop4_lane0", SIG_PRD, 32'(pack4(0, 0, 0, 36)));
      checkOutput();

      // Sparse request compacts into the requesting lanes only.
      resetDut();
      i_alloc_req = 4'b1010;
      #1;
      expectVal("sparse_prd", SIG_PRD, 32'(pack4(33, 0, 32, 0)));
      checkOutput();
      applyStimulus(4'b1010, 1'b1, 4'b0000, '0);
      expectVal("sparse_count", SIG_COUNT, 32'd94);
      checkOutput();

      // Same-cycle push and pop: no bypass, 40/41 go to the tail.
      resetDut();
      applyStimulus(4'b0001, 1'b1, 4'b0101, pack4(0, 41, 0, 40));
      expectVal("pushpop_count", SIG_COUNT, 32'd97);
      checkOutput();

      // Drain to two entries; those must be the released 40 and 41.
      for (int n = 0; n < 23; n++) applyStimulus(4'b1111, 1'b1, 4'b0000, '0);
      applyStimulus(4'b0111, 1'b1, 4'b0000, '0);
      expectVal("drain_count2", SIG_COUNT, 32'd2);
      checkOutput();
      applyStimulus(4'b0111, 1'b1, 4'b0000, '0);
      i_alloc_req = 4'b0011;
      #1;
      expectVal("last_two", SIG_PRD, 32'(pack4(0, 0, 41, 40)));
      checkOutput();
      applyStimulus(4'b0011, 1'b1, 4'b0000, '0);
      expectVal("drained_empty", SIG_EMPTY, 32'd1);
      checkOutput();

      // Streaming groups of four so the tail crosses index 127.
      for (int n = 0; n < 12; n++) begin
         rq = (n == 0) ? 4'b0000 : 4'b1111;
         applyStimulus(rq, 1'b1, 4'b1111, pack4(53 + 4*n, 52 + 4*n, 51 + 4*n, 50 + 4*n));
      end
      applyStimulus(4'b1111, 1'b1, 4'b0000, '0);

      // Mixed random traffic, releases throttled to keep the pool legal.
      for (int n = 0; n < 24; n++) begin
         rq  = 4'($urandom_range(0, 15));
         en  = 4'($urandom_range(0, 15));
         tg  = pack4($urandom_range(1, 127), $urandom_range(1, 127),
                     $urandom_range(1, 127), $urandom_range(1, 127));
         net = modelQ.size() + $countones(en);
         if (modelQ.size() >= $countones(rq)) net = net - $countones(rq);
         if (net > NPREG - NAREG) en = '0;
         applyStimulus(rq, 1'b1, en, tg);
      end

      // Release of tag 0: flagged, dropped, and the flag sticks.
      net = modelQ.size();
      applyStimulus(4'b0000, 1'b0, 4'b0001, '0);
      expectVal("tag0_error", SIG_ERROR, 32'd1);
      expectVal("tag0_count", SIG_COUNT, 32'(net));
      checkOutput();
      applyStimulus(4'b0000, 1'b0, 4'b0000, '0);

      // Reset in the middle of an active cycle.
      @(negedge i_clk);
      i_alloc_req = 4'b1111;
      i_alloc_we  = 1'b1;
      i_com_en    = 4'b1111;
      i_com_prd4x = pack4(60, 61, 62, 63);
      #2;
      resetDut();
      applyStimulus(4'b0001, 1'b1, 4'b0000, '0);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time guard so a broken DUT or bench can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
